// File: rtl/bcd_add_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_add_sequencer_if : command/result bundle for bcd_add_sequencer          |
// | Optional subtract select is present only with BCD_SEQ_SUB_EN.               |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface bcd_add_sequencer_if #(
    parameter int DIGITS = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  carry_out;
    logic                  invalid;
`ifdef BCD_SEQ_SUB_EN
    logic                  sub;

    modport master (output start, a, b, sub, input ready, done, sum, carry_out, invalid);
    modport slave  (input  start, a, b, sub, output ready, done, sum, carry_out, invalid);
`else
    modport master (output start, a, b, input ready, done, sum, carry_out, invalid);
    modport slave  (input  start, a, b, output ready, done, sum, carry_out, invalid);
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_add_sequencer : DIGITS-digit packed-BCD adder built from one byte stage |
// | stepped LSB first; BCD_SEQ_SUB_EN adds nines-complement subtraction.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module bcd_add_sequencer #(
    parameter int DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_add_sequencer_if.slave bus
);
    localparam int c_W      = 4 * DIGITS;
    localparam int c_STEPS  = DIGITS / 2;
    localparam int c_STEP_W = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(c_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_last;

    logic [c_W-1:0]        r_a;
    logic [c_W-1:0]        r_b;
    logic [c_W-1:0]        r_acc;
    logic [c_STEP_W-1:0]   r_step;
    logic                  r_carry;
    logic                  r_inv;
    logic [c_W-1:0]        r_sum;
    logic                  r_carry_out;
    logic                  r_invalid;

    logic                  w_sub_mode;
    logic                  w_init_carry;
    logic [3:0]            w_b0;
    logic [3:0]            w_b1;
    logic [4:0]            w_lo;
    logic [4:0]            w_hi;
    logic [7:0]            w_byte;
    logic [c_W-1:0]        w_acc_nxt;

    // Returns {carry, digit}; digits above 9 still follow the same rule.
    function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic c);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, x} + {1'b0, y} + {4'b0, c};
        t = s + 5'd6;
        if (s > 5'd9) digit_add = {1'b1, t[3:0]};
        else          digit_add = {1'b0, s[3:0]};
    endfunction

    function automatic logic has_bad_digit(input logic [c_W-1:0] x);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

`ifdef BCD_SEQ_SUB_EN
    logic r_sub;
    assign w_sub_mode   = r_sub;
    assign w_init_carry = bus.sub;
`else
    assign w_sub_mode   = 1'b0;
    assign w_init_carry = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_step == c_LAST_STEP) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operands shift right each step so the stage always sees byte 0.
    assign w_b0   = w_sub_mode ? (4'd9 - r_b[3:0]) : r_b[3:0];
    assign w_b1   = w_sub_mode ? (4'd9 - r_b[7:4]) : r_b[7:4];
    assign w_lo   = digit_add(r_a[3:0], w_b0, r_carry);
    assign w_hi   = digit_add(r_a[7:4], w_b1, w_lo[4]);
    assign w_byte = {w_hi[3:0], w_lo[3:0]};

    generate
        if (DIGITS > 2) begin : g_multi_byte
            assign w_acc_nxt = {w_byte, r_acc[c_W-1:8]};
        end else begin : g_single_byte
            assign w_acc_nxt = w_byte;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_step      <= '0;
            r_carry     <= 1'b0;
            r_inv       <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_invalid   <= 1'b0;
`ifdef BCD_SEQ_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_acc   <= '0;
            r_step  <= '0;
            r_carry <= w_init_carry;
            r_inv   <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
`ifdef BCD_SEQ_SUB_EN
            r_sub   <= bus.sub;
`endif
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 8;
            r_b     <= r_b >> 8;
            r_acc   <= w_acc_nxt;
            r_carry <= w_hi[4];
            r_step  <= r_step + c_STEP_W'(1);
            if (w_last) begin
                r_sum       <= w_acc_nxt;
                r_carry_out <= w_hi[4];
                r_invalid   <= r_inv;
            end
        end
    end

    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
    assign bus.invalid   = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_bcd_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bcd_add_sequencer : directed + random checks against a decimal model     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_bcd_add_sequencer;
    localparam int DIGITS = 8;
    localparam int W      = 4 * DIGITS;
    // Cycles counted inclusively from the cycle start is driven to the done cycle.
    localparam int LAT    = DIGITS / 2 + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_add_sequencer_if #(.DIGITS(DIGITS)) bus ();
    bcd_add_sequencer #(.DIGITS(DIGITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic longint bcd2int(input logic [W-1:0] x);
        longint v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
        return r;
    endfunction

    // Decimal reference: sum modulo 10^DIGITS, carry = overflow (or no-borrow).
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         output logic [W-1:0] es, output logic ec);
        longint aa = bcd2int(av);
        longint bb = bcd2int(bv);
        longint m  = pow10(DIGITS);
        if (!sv) begin
            ec = (aa + bb) >= m;
            es = int2bcd((aa + bb) % m);
        end else begin
            ec = aa >= bb;
            es = int2bcd(ec ? (aa - bb) : (aa - bb + m));
        end
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        bus.a = av;
        bus.b = bv;
`ifdef BCD_SEQ_SUB_EN
        bus.sub = sv;
`else
        if (sv) $fatal(1, "subtract requested without BCD_SEQ_SUB_EN");
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic [W-1:0] exp_sum, input logic exp_c,
                          input logic exp_inv);
        int   cyc;
        logic busy_ok;
        @(negedge clk);
        check({tag, ":ready_before"}, 64'(bus.ready), 64'd1);
        bus.start = 1'b1;
        drive(av, bv, sv);
        @(negedge clk);
        bus.start = 1'b0;
        drive(rand_bcd(), rand_bcd(), 1'b0);
        cyc     = 2;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < LAT + 10) begin
            if (bus.ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (bus.ready !== 1'b0) busy_ok = 1'b0;
        check({tag, ":latency"}, 64'(cyc), 64'(LAT));
        check({tag, ":busy"},    64'(busy_ok), 64'd1);
        check({tag, ":sum"},     64'(bus.sum), 64'(exp_sum));
        check({tag, ":carry"},   64'(bus.carry_out), 64'(exp_c));
        check({tag, ":invalid"}, 64'(bus.invalid), 64'(exp_inv));
        @(negedge clk);
        check({tag, ":done_1cyc"}, 64'(bus.done), 64'd0);
        check({tag, ":ready_after"}, 64'(bus.ready), 64'd1);
        check({tag, ":sum_hold"}, 64'(bus.sum), 64'(exp_sum));
    endtask

    initial begin
        logic [W-1:0] av, bv, es;
        logic         ec;
        logic [W-1:0] qs[$];
        logic         qc[$];
        int           last_done, n_done, bad_done;

        bus.start = 1'b0;
        drive('0, '0, 1'b0);

        // Reset values while rst_n is held low
        #12;
        check("reset:ready",   64'(bus.ready), 64'd1);
        check("reset:done",    64'(bus.done), 64'd0);
        check("reset:sum",     64'(bus.sum), 64'd0);
        check("reset:carry",   64'(bus.carry_out), 64'd0);
        check("reset:invalid", 64'(bus.invalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add62_59",  32'h00000062, 32'h00000059, 1'b0, 32'h00000121, 1'b0, 1'b0);
        run_op("ripple",    32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        // digit0 3+5=8; digit1 4+11=15 -> 5 carry 1; digit2 0+0+1=1
        run_op("bad_digit", 32'h00000043, 32'h000000B5, 1'b0, 32'h00000158, 1'b0, 1'b1);
        run_op("max",       32'h99999999, 32'h99999999, 1'b0, 32'h99999998, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            av = rand_bcd();
            bv = rand_bcd();
            model(av, bv, 1'b0, es, ec);
            run_op($sformatf("rand_add%0d", i), av, bv, 1'b0, es, ec, 1'b0);
        end

        // Back-to-back with start held high and fresh operands every cycle
        last_done = -1;
        n_done    = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (bus.done === 1'b1) begin
                if (qs.size() == 0) begin
                    check("b2b:unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("b2b:sum",   64'(bus.sum), 64'(qs.pop_front()));
                    check("b2b:carry", 64'(bus.carry_out), 64'(qc.pop_front()));
                end
                if (last_done >= 0) check("b2b:period", 64'(cyc - last_done), 64'(LAT));
                last_done = cyc;
                n_done++;
            end
            av = rand_bcd();
            bv = rand_bcd();
            drive(av, bv, 1'b0);
            if (bus.ready === 1'b1) begin
                model(av, bv, 1'b0, es, ec);
                qs.push_back(es);
                qc.push_back(ec);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < LAT + 4 && qs.size() != 0; cyc++) begin
            if (bus.done === 1'b1) begin
                check("b2b:drain_sum",   64'(bus.sum), 64'(qs.pop_front()));
                check("b2b:drain_carry", 64'(bus.carry_out), 64'(qc.pop_front()));
                n_done++;
            end
            @(negedge clk);
        end
        check("b2b:queue_empty", 64'(qs.size()), 64'd0);
        check("b2b:done_count_ok", 64'(n_done >= 9), 64'd1);

        // Reset mid-operation
        run_op("pre_reset", 32'h55555555, 32'h55555555, 1'b0, 32'h11111110, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        drive(32'h12345678, 32'h11111111, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst:ready", 64'(bus.ready), 64'd1);
        check("midrst:done",  64'(bus.done), 64'd0);
        check("midrst:sum",   64'(bus.sum), 64'd0);
        check("midrst:carry", 64'(bus.carry_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad_done = 0;
        for (int cyc = 0; cyc < LAT + 2; cyc++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) bad_done++;
        end
        check("midrst:no_done", 64'(bad_done), 64'd0);
        run_op("post_reset", 32'h00000029, 32'h00000068, 1'b0, 32'h00000097, 1'b0, 1'b0);

`ifdef BCD_SEQ_SUB_EN
        run_op("sub100_1", 32'h00000100, 32'h00000001, 1'b1, 32'h00000099, 1'b1, 1'b0);
        run_op("sub1_2",   32'h00000001, 32'h00000002, 1'b1, 32'h99999999, 1'b0, 1'b0);
        run_op("sub_eq",   32'h00004321, 32'h00004321, 1'b1, 32'h00000000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            av = rand_bcd();
            bv = rand_bcd();
            model(av, bv, 1'b1, es, ec);
            run_op($sformatf("rand_sub%0d", i), av, bv, 1'b1, es, ec, 1'b0);
            model(av, bv, 1'b0, es, ec);
            run_op($sformatf("rand_addsub%0d", i), av, bv, 1'b0, es, ec, 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
